arbitro_mux_8bits: RTL and testbench

Two-requester round-robin arbiter that owns the select line of the shared 8-bit 2:1 datapath multiplexer. Each requester raises a request, receives an exclusive grant, streams 8-bit data through the mux while granted, and releases the grant. The block drives the mux select, registers the selected byte with a valid flag, and sits between the processor's bus masters and any shared 8-bit destination.

---
 rtl/arbitro_mux_8bits.sv | 145 ++++++++++++++
 tb/tb_arbitro_mux_8bits.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux_8bits.sv
// Round-robin arbiter for two requesters. It owns the select of a shared 8-bit 2:1 mux and registers the selected byte.
// Optional forced release after TIMEOUT granted cycles when ARBITRO_TIMEOUT_EN is defined.
module arbitro_mux_8bits #(
   parameter  int unsigned TIMEOUT = 16,
   localparam int unsigned DADO_W  = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req1,
   input  logic              req2,
   input  logic              libera1,
   input  logic              libera2,
   input  logic [DADO_W-1:0] dado1,
   input  logic [DADO_W-1:0] dado2,
   output logic              gnt1,
   output logic              gnt2,
   output logic              controle,
   output logic [DADO_W-1:0] saida,
   output logic              saida_valida,
   output logic              erro_timeout
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONCEDE1 = 2'd1,
      CONCEDE2 = 2'd2
   } estado_t;

   estado_t estado;
   logic    ultimo2;     // 1: requester 2 was the last one served
   logic    limite_c;
   logic    solta1_c, solta2_c;
   logic    revoga1_c, revoga2_c;
   logic    fim1_c, fim2_c;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_invalido
      $error("TIMEOUT must be within 2..255");
   end

   // A voluntary release (libera or dropped request) always wins over the timeout
   assign solta1_c  = gnt1 & (libera1 | ~req1);
   assign solta2_c  = gnt2 & (libera2 | ~req2);
   assign revoga1_c = gnt1 & ~solta1_c & limite_c;
   assign revoga2_c = gnt2 & ~solta2_c & limite_c;
   assign fim1_c    = solta1_c | revoga1_c;
   assign fim2_c    = solta2_c | revoga2_c;

`ifdef ARBITRO_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] contador;
   logic             entra_c;

   assign limite_c = (contador == CNT_W'(TIMEOUT - 1));
   assign entra_c  = ((estado == OCIOSO) & (req1 | req2)) | (fim1_c & req2) | (fim2_c & req1);

   // Granted-cycle counter; restarts on every new grant, including handovers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         contador     <= '0;
         erro_timeout <= 1'b0;
      end else begin
         erro_timeout <= revoga1_c | revoga2_c;
         if (entra_c) begin
            contador <= '0;
         end else if (gnt1 | gnt2) begin
            contador <= contador + CNT_W'(1);
         end
      end
   end
`else
   assign limite_c     = 1'b0;
   assign erro_timeout = 1'b0;
`endif

   // Grant FSM with registered grants and mux select
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado   <= OCIOSO;
         gnt1     <= 1'b0;
         gnt2     <= 1'b0;
         controle <= 1'b0;
         ultimo2  <= 1'b1;
      end else begin
         case (estado)
            OCIOSO: begin
               if (req1 && (!req2 || ultimo2)) begin
                  estado   <= CONCEDE1;
                  gnt1     <= 1'b1;
                  controle <= 1'b0;
               end else if (req2) begin
                  estado   <= CONCEDE2;
                  gnt2     <= 1'b1;
                  controle <= 1'b1;
               end
            end
            CONCEDE1: begin
               if (fim1_c) begin
                  ultimo2 <= 1'b0;
                  gnt1    <= 1'b0;
                  if (req2) begin
                     estado   <= CONCEDE2;
                     gnt2     <= 1'b1;
                     controle <= 1'b1;
                  end else begin
                     estado <= OCIOSO;
                  end
               end
            end
            CONCEDE2: begin
               if (fim2_c) begin
                  ultimo2 <= 1'b1;
                  gnt2    <= 1'b0;
                  if (req1) begin
                     estado   <= CONCEDE1;
                     gnt1     <= 1'b1;
                     controle <= 1'b0;
                  end else begin
                     estado <= OCIOSO;
                  end
               end
            end
            default: begin
               estado <= OCIOSO;
               gnt1   <= 1'b0;
               gnt2   <= 1'b0;
            end
         endcase
      end
   end

   // Capture the selected byte on every granted edge
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         saida        <= '0;
         saida_valida <= 1'b0;
      end else if (gnt1 | gnt2) begin
         saida        <= controle ? dado2 : dado1;
         saida_valida <= 1'b1;
      end else begin
         saida_valida <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arbitro_mux_8bits.sv
// Self-checking bench for arbitro_mux_8bits: directed scenarios plus randomized traffic against a behavioural model.
module tb_arbitro_mux_8bits;

   localparam int unsigned TMO = 4;
`ifdef ARBITRO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       req1    = 1'b0;
   logic       req2    = 1'b0;
   logic       libera1 = 1'b0;
   logic       libera2 = 1'b0;
   logic [7:0] dado1   = 8'h00;
   logic [7:0] dado2   = 8'h00;
   logic       gnt1, gnt2, controle, saida_valida, erro_timeout;
   logic [7:0] saida;

   int checks = 0;
   int errors = 0;

   // Model: owner of the mux (0 none, 1 or 2), last served, granted edges so far
   int         m_dono   = 0;
   int         m_ultimo = 2;
   int         m_conta  = 0;
   logic       m_ctrl   = 1'b0;
   logic [7:0] m_saida  = 8'h00;
   logic       m_valida = 1'b0;
   logic       m_erro   = 1'b0;

   arbitro_mux_8bits #(.TIMEOUT(TMO)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req1         (req1),
      .req2         (req2),
      .libera1      (libera1),
      .libera2      (libera2),
      .dado1        (dado1),
      .dado2        (dado2),
      .gnt1         (gnt1),
      .gnt2         (gnt2),
      .controle     (controle),
      .saida        (saida),
      .saida_valida (saida_valida),
      .erro_timeout (erro_timeout)
   );

   always #5 clock = ~clock;

   task automatic model_step();
      int  x;
      int  outro;
      bit  liberou;
      bit  estourou;
      bit  outro_pede;
      if (!reset_n) begin
         m_dono = 0; m_ultimo = 2; m_conta = 0; m_ctrl = 1'b0;
         m_saida = 8'h00; m_valida = 1'b0; m_erro = 1'b0;
         return;
      end
      m_valida = (m_dono != 0);
      if (m_dono != 0) m_saida = m_ctrl ? dado2 : dado1;
      m_erro = 1'b0;
      if (m_dono == 0) begin
         if (req1 && req2) x = 3 - m_ultimo;
         else if (req1)    x = 1;
         else if (req2)    x = 2;
         else              x = 0;
         if (x != 0) begin
            m_dono = x; m_ctrl = (x == 2); m_conta = 0;
         end
      end else begin
         x          = m_dono;
         outro      = 3 - x;
         liberou    = (x == 1) ? (libera1 || !req1) : (libera2 || !req2);
         estourou   = TO_EN && !liberou && (m_conta == int'(TMO) - 1);
         outro_pede = (outro == 1) ? req1 : req2;
         if (liberou || estourou) begin
            m_ultimo = x;
            m_erro   = estourou;
            if (outro_pede) begin
               m_dono = outro; m_ctrl = (outro == 2); m_conta = 0;
            end else begin
               m_dono = 0;
            end
         end else begin
            m_conta++;
         end
      end
   endtask

   function automatic logic [12:0] esperado();
      return {m_dono == 1, m_dono == 2, m_ctrl, m_saida, m_valida, m_erro};
   endfunction

   function automatic logic [12:0] observado();
      return {gnt1, gnt2, controle, saida, saida_valida, erro_timeout};
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      req1 = 1'b0; req2 = 1'b0; libera1 = 1'b0; libera2 = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req1 = 1'b1; req2 = 1'b1; dado1 = 8'hA5; dado2 = 8'h5A;
      tick(); tick();
      checks++;
      if (observado() !== 13'h0) begin
         errors++; $display("FAIL reset_zero got=%h want=%h", observado(), 13'h0);
      end
      checks++;
      if (observado() !== esperado()) begin
         errors++; $display("FAIL reset_model got=%h want=%h", observado(), esperado());
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if ({gnt1, gnt2, controle, saida_valida} !== 4'b1000) begin
         errors++; $display("FAIL first_grant got=%b want=1000", {gnt1, gnt2, controle, saida_valida});
      end
      tick();
      checks++;
      if ({saida, saida_valida} !== {8'hA5, 1'b1}) begin
         errors++; $display("FAIL first_byte got=%h/%b want=a5/1", saida, saida_valida);
      end
   endtask

   task automatic test_handover();
      dado2 = 8'h3C; libera1 = 1'b1;
      tick();
      checks++;
      if ({gnt1, gnt2, controle} !== 3'b011) begin
         errors++; $display("FAIL handover_grant got=%b want=011", {gnt1, gnt2, controle});
      end
      libera1 = 1'b0; req1 = 1'b0;
      tick();
      checks++;
      if ({gnt2, saida, saida_valida} !== {1'b1, 8'h3C, 1'b1}) begin
         errors++; $display("FAIL handover_byte got=%b/%h/%b want=1/3c/1", gnt2, saida, saida_valida);
      end
      checks++;
      if (observado() !== esperado()) begin
         errors++; $display("FAIL handover_model got=%h want=%h", observado(), esperado());
      end
      req2 = 1'b0;
      tick(); tick();
   endtask

   task automatic test_alternate();
      int seq[$];
      int dono_ant;
      int dono_obs;
      int want[4] = '{1, 2, 1, 2};
      do_reset();
      req1 = 1'b1; req2 = 1'b1;
      dono_ant = 0;
      for (int i = 0; i < 24; i++) begin
         libera1 = (m_dono == 1) && (m_conta == 2);
         libera2 = (m_dono == 2) && (m_conta == 2);
         tick();
         checks++;
         if (gnt1 && gnt2) begin
            errors++; $display("FAIL alt_exclusive got=%b%b want=not 11", gnt1, gnt2);
         end
         dono_obs = gnt1 ? 1 : (gnt2 ? 2 : 0);
         if (dono_obs != 0 && dono_obs != dono_ant) seq.push_back(dono_obs);
         dono_ant = dono_obs;
      end
      libera1 = 1'b0; libera2 = 1'b0;
      checks++;
      if (seq.size() < 4) begin
         errors++; $display("FAIL alt_count got=%0d want>=4", seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (seq[i] != want[i]) begin
               errors++; $display("FAIL alt_order idx=%0d got=%0d want=%0d", i, seq[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_libera_ignored();
      do_reset();
      req1 = 1'b1;
      tick();
      libera2 = 1'b1;
      tick();
      checks++;
      if ({gnt1, gnt2} !== 2'b10) begin
         errors++; $display("FAIL libera2_ignored got=%b want=10", {gnt1, gnt2});
      end
      libera2 = 1'b0;
      tick();
      checks++;
      if ({gnt1, gnt2} !== 2'b10) begin
         errors++; $display("FAIL libera2_after got=%b want=10", {gnt1, gnt2});
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req1 = 1'b1; dado1 = 8'hFF;
      tick(); tick();
      checks++;
      if ({saida, saida_valida} !== {8'hFF, 1'b1}) begin
         errors++; $display("FAIL mid_before got=%h/%b want=ff/1", saida, saida_valida);
      end
      reset_n = 1'b0;
      tick();
      checks++;
      if ({gnt1, saida, saida_valida} !== {1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL mid_reset got=%b/%h/%b want=0/00/0", gnt1, saida, saida_valida);
      end
      reset_n = 1'b1; req1 = 1'b0;
   endtask

   task automatic test_timeout();
      int  alto;
      bit  achou;
      do_reset();
      req1 = 1'b1;
      alto = 0; achou = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (gnt1) begin
            alto++;
         end else if (alto != 0) begin
            achou = 1'b1;
            break;
         end
      end
      checks++;
      if (TO_EN && (!achou || alto != int'(TMO) || erro_timeout !== 1'b1)) begin
         errors++; $display("FAIL timeout_first got=high%0d/err%b want=high%0d/err1", alto, erro_timeout, TMO);
      end else if (!TO_EN && (achou || erro_timeout !== 1'b0)) begin
         errors++; $display("FAIL hold_forever got=high%0d/err%b want=held/err0", alto, erro_timeout);
      end
      tick();
      checks++;
      if ({gnt1, erro_timeout} !== 2'b10) begin
         errors++; $display("FAIL timeout_pulse got=%b want=10", {gnt1, erro_timeout});
      end
      req2 = 1'b1;
      achou = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (erro_timeout) begin
            achou = 1'b1;
            break;
         end
      end
      checks++;
      if (TO_EN && (!achou || {gnt1, gnt2, controle} !== 3'b011)) begin
         errors++; $display("FAIL timeout_handover got=found%b/%b want=found1/011", achou, {gnt1, gnt2, controle});
      end else if (!TO_EN && (achou || gnt1 !== 1'b1)) begin
         errors++; $display("FAIL hold_pending got=err%b/gnt1=%b want=err0/gnt1=1", achou, gnt1);
      end
      checks++;
      if (observado() !== esperado()) begin
         errors++; $display("FAIL timeout_model got=%h want=%h", observado(), esperado());
      end
      req1 = 1'b0; req2 = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset_n = ($urandom_range(0, 59) != 0);
         req1    = ($urandom_range(0, 9) < 7);
         req2    = ($urandom_range(0, 9) < 7);
         libera1 = ($urandom_range(0, 3) == 0);
         libera2 = ($urandom_range(0, 3) == 0);
         dado1   = 8'($urandom);
         dado2   = 8'($urandom);
         tick();
         checks++;
         if (observado() !== esperado()) begin
            errors++; $display("FAIL random_cycle%0d got=%h want=%h", i, observado(), esperado());
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_handover();
      test_alternate();
      test_libera_ignored();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
